pll_rst_seq: RTL and testbench
==============================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before system reset release (range 2..65535).
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 16: minimum sys_rstn low time after any reset cause (range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: cycles waited for lock before a PLL reset pulse; used only with the configuration feature.
REQ-004 SHALL have port clkin, input, 1: free-running reference clock, the same clock that feeds the PLL; the only clock.
REQ-005 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pll_lock, input, 1: PLL LOCK, asynchronous to clkin.
REQ-007 SHALL have port sw_rst_req, input, 1: synchronous software reset request, level-sensitive.
REQ-008 SHALL have port pll_reset, output, 1: active-high PLL RESET drive.
REQ-009 SHALL have port sys_rstn, output, 1: registered active-low system reset.
REQ-010 SHALL have port ready, output, 1: high exactly while in RUN.
REQ-011 SHALL have port lock_lost_cnt, output, 8: count of lock-loss events in RUN, saturating.

Function
REQ-012 SHALL synchronize pll_lock through 2 clkin flops to lock_s; all logic uses lock_s only.
REQ-013 SHALL implement FSM states HOLD, WAIT_LOCK, STABILIZE, RUN; sys_rstn low in all states except RUN.
REQ-014 HOLD: count RST_HOLD_CYCLES cycles, then go to WAIT_LOCK; sw_rst_req high in HOLD restarts the count.
REQ-015 WAIT_LOCK: lock_s=1 -> STABILIZE with stable counter cleared.
REQ-016 STABILIZE: counter increments while lock_s=1; lock_s=0 -> WAIT_LOCK; on reaching LOCK_STABLE_CYCLES -> RUN.
REQ-017 RUN: sys_rstn=1 and ready=1, both registered, asserted the cycle after entry to RUN.
REQ-018 RUN with lock_s=0 -> HOLD, lock_lost_cnt increments by 1, saturating at 255.
REQ-019 sw_rst_req=1 in WAIT_LOCK, STABILIZE or RUN -> HOLD; simultaneous lock loss and sw_rst_req in RUN -> HOLD with lock_lost_cnt incremented.
REQ-020 sys_rstn SHALL go low the first cycle after leaving RUN; no glitches on sys_rstn, which is a flop output.
REQ-021 Without the configuration feature, pll_reset SHALL be held at 0.

Reset
REQ-022 resetn low SHALL asynchronously force: state HOLD, all counters 0, synchronizer flops 0, sys_rstn=0, ready=0, pll_reset=0, lock_lost_cnt=0.
REQ-023 Release of resetn SHALL take effect on the next clkin edge; resetn low mid-operation SHALL abort any state or pll_reset pulse immediately.

Configuration
REQ-024 Macro PLL_RST_TIMEOUT_EN SHALL, when defined, add a lock-timeout counter active in WAIT_LOCK and STABILIZE, cleared on entry to WAIT_LOCK.
REQ-025 With PLL_RST_TIMEOUT_EN, reaching TIMEOUT_CYCLES without RUN SHALL drive pll_reset=1 for exactly 8 cycles, then return to HOLD with the counter cleared.
REQ-026 Without PLL_RST_TIMEOUT_EN, no timeout logic SHALL exist and WAIT_LOCK waits indefinitely.

Verification
REQ-027 resetn pulse low, pll_lock=1 constant, LOCK_STABLE_CYCLES=1024, RST_HOLD_CYCLES=16 -> sys_rstn and ready rise 16+2+1024+1 cycles (±1) after reset release.
REQ-028 In RUN, drop pll_lock for 5 cycles -> sys_rstn low within 3 cycles, lock_lost_cnt=1, reset release repeats the full sequence.
REQ-029 pll_lock toggles every 500 cycles -> never reaches RUN, sys_rstn stays 0, lock_lost_cnt stays 0.
REQ-030 In RUN, one-cycle sw_rst_req -> sys_rstn low for at least 16 cycles, lock_lost_cnt unchanged.
REQ-031 With PLL_RST_TIMEOUT_EN, TIMEOUT_CYCLES=100, pll_lock=0 -> pll_reset high for 8 cycles, recurring at a fixed period; without the macro, pll_reset stays 0.
REQ-032 Force 300 lock losses -> lock_lost_cnt saturates at 255 and returns to 0 only on resetn.

Source files
------------

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: holds sys_rstn low until a synchronized PLL lock has been stable long enough.
// Optional macro PLL_RST_TIMEOUT_EN adds a lock timeout that pulses pll_reset for 8 cycles.
//
// state      | meaning
// HOLD       | sys_rstn low for RST_HOLD_CYCLES after any reset cause
// WAIT_LOCK  | waiting for lock_s to go high
// STABILIZE  | counting consecutive lock_s cycles up to LOCK_STABLE_CYCLES
// RUN        | lock stable, sys_rstn and ready high
// PLL_PULSE  | pll_reset driven high for 8 cycles (timeout build only)

module pll_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       pll_reset,
  output logic       sys_rstn,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam logic [2:0] HOLD      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABILIZE = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;

  localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);

  logic        lock_m, lock_s;
  logic [2:0]  state, state_base, state_nxt;
  logic [15:0] cnt, cnt_base, cnt_nxt;
  logic        run_nxt;

`ifdef PLL_RST_TIMEOUT_EN
  localparam logic [2:0]  PLL_PULSE    = 3'd4;
  localparam logic [15:0] PULSE_LAST   = 16'd7;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // One shared counter: hold time, stable-lock streak and pulse width never overlap.
  always_comb begin
    state_base = state;
    cnt_base   = cnt;
    case (state)
      HOLD: begin
        if (sw_rst_req) begin
          cnt_base = '0;
        end else if (cnt == HOLD_LAST) begin
          state_base = WAIT_LOCK;
          cnt_base   = '0;
        end else begin
          cnt_base = cnt + 16'd1;
        end
      end
      WAIT_LOCK: begin
        if (sw_rst_req) begin
          state_base = HOLD;
          cnt_base   = '0;
        end else if (lock_s) begin
          state_base = STABILIZE;
          cnt_base   = '0;
        end
      end
      STABILIZE: begin
        if (sw_rst_req) begin
          state_base = HOLD;
          cnt_base   = '0;
        end else if (!lock_s) begin
          state_base = WAIT_LOCK;
          cnt_base   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_base = RUN;
          cnt_base   = '0;
        end else begin
          cnt_base = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s || sw_rst_req) begin
          state_base = HOLD;
          cnt_base   = '0;
        end
      end
`ifdef PLL_RST_TIMEOUT_EN
      PLL_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_base = HOLD;
          cnt_base   = '0;
        end else begin
          cnt_base = cnt + 16'd1;
        end
      end
`endif
      default: begin
        state_base = HOLD;
        cnt_base   = '0;
      end
    endcase
  end

`ifdef PLL_RST_TIMEOUT_EN
  logic [15:0] to_cnt, to_cnt_nxt;
  logic        to_hit;
  logic        pll_reset_q;

  // Timeout only fires when the cycle would otherwise neither reach RUN nor go to HOLD.
  always_comb begin
    state_nxt = state_base;
    cnt_nxt   = cnt_base;
    to_hit    = ((state == WAIT_LOCK) || (state == STABILIZE)) && (to_cnt == TIMEOUT_LAST);
    if (to_hit && (state_base != RUN) && (state_base != HOLD)) begin
      state_nxt = PLL_PULSE;
      cnt_nxt   = '0;
    end
    if ((state_nxt == STABILIZE) || ((state_nxt == WAIT_LOCK) && (state == WAIT_LOCK)))
      to_cnt_nxt = to_cnt + 16'd1;
    else
      to_cnt_nxt = '0;
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      pll_reset_q <= 1'b0;
    end else begin
      to_cnt      <= to_cnt_nxt;
      pll_reset_q <= (state_nxt == PLL_PULSE);
    end
  end

  assign pll_reset = pll_reset_q;
`else
  assign state_nxt = state_base;
  assign cnt_nxt   = cnt_base;
  assign pll_reset = 1'b0;

  // TIMEOUT_CYCLES has no effect unless the timeout is compiled in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign run_nxt = (state == RUN) && (state_nxt == RUN);

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state         <= HOLD;
      cnt           <= '0;
      sys_rstn      <= 1'b0;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sys_rstn <= run_nxt;
      ready    <= run_nxt;
      if ((state == RUN) && !lock_s && (lock_lost_cnt != 8'hFF))
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed vector table, timing corners and a
// randomized run against a behavioural model of the sequencing rules.

module tb_pll_rst_seq;

  localparam int H  = 16;
  localparam int LB = 20;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       a_pll_reset, a_sys_rstn, a_ready;
  logic [7:0] a_lost;
  logic       b_pll_reset, b_sys_rstn, b_ready;
  logic [7:0] b_lost;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_rst_seq dut_a (
    .clkin(clk), .resetn(resetn), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .pll_reset(a_pll_reset), .sys_rstn(a_sys_rstn), .ready(a_ready), .lock_lost_cnt(a_lost)
  );

  pll_rst_seq #(.LOCK_STABLE_CYCLES(LB), .RST_HOLD_CYCLES(H)) dut_b (
    .clkin(clk), .resetn(resetn), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .pll_reset(b_pll_reset), .sys_rstn(b_sys_rstn), .ready(b_ready), .lock_lost_cnt(b_lost)
  );

`ifdef PLL_RST_TIMEOUT_EN
  logic       c_pll_reset, c_sys_rstn, c_ready;
  logic [7:0] c_lost;
  pll_rst_seq #(.LOCK_STABLE_CYCLES(LB), .RST_HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)) dut_c (
    .clkin(clk), .resetn(resetn), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .pll_reset(c_pll_reset), .sys_rstn(c_sys_rstn), .ready(c_ready), .lock_lost_cnt(c_lost)
  );
`endif

  // Behavioural model of dut_b, phrased as the sequencing rules themselves.
  typedef enum int {PH_HOLD, PH_WAIT, PH_STAB, PH_RUN} phase_t;
  phase_t m_ph;
  int     m_age, m_streak, m_lost;
  bit     m_rstn, m_sync0, m_sync1;

  typedef struct {
    bit lk;
    bit sw;
    int n;
    bit exp_rstn;
    int exp_lost;
  } vec_t;
  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_HOLD; m_age = 0; m_streak = 0; m_lost = 0;
    m_rstn = 0; m_sync0 = 0; m_sync1 = 0;
  endtask

  task automatic enter_hold();
    m_ph = PH_HOLD;
    m_age = 0;
  endtask

  task automatic model_step(input bit lk, input bit sw);
    bit ls;
    bit was_run;
    ls = m_sync1;
    m_sync1 = m_sync0;
    m_sync0 = lk;
    was_run = (m_ph == PH_RUN);
    case (m_ph)
      PH_HOLD: begin
        if (sw) m_age = 0;
        else begin
          m_age++;
          if (m_age == H) m_ph = PH_WAIT;
        end
      end
      PH_WAIT: begin
        if (sw) enter_hold();
        else if (ls) begin m_ph = PH_STAB; m_streak = 0; end
      end
      PH_STAB: begin
        if (sw) enter_hold();
        else if (!ls) m_ph = PH_WAIT;
        else begin
          m_streak++;
          if (m_streak == LB) m_ph = PH_RUN;
        end
      end
      default: begin
        if (!ls) begin
          if (m_lost < 255) m_lost++;
          enter_hold();
        end else if (sw) enter_hold();
      end
    endcase
    m_rstn = was_run && (m_ph == PH_RUN);
  endtask

  task automatic chk_cycle();
    chk("b_sys_rstn", b_sys_rstn, m_rstn);
    chk("b_ready", b_ready, m_rstn);
    chk("b_lost", b_lost, m_lost);
    chk("b_pll_reset", b_pll_reset, 0);
    chk("a_pll_reset", a_pll_reset, 0);
  endtask

  task automatic tick(input bit lk, input bit sw);
    pll_lock = lk;
    sw_rst_req = sw;
    model_step(lk, sw);
    @(negedge clk);
    chk_cycle();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pll_lock = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    #1;
    chk("rst_a_sys_rstn", a_sys_rstn, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_lost", a_lost, 0);
    chk("rst_b_sys_rstn", b_sys_rstn, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_b_lost", b_lost, 0);
    chk("rst_b_pll_reset", b_pll_reset, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    bit a_hi;
    bit lk;
    bit sw;
    int remaining;

    // Hand-derived timeline for dut_b (H=16, LB=20): release at edge 38 after reset.
    vecs[0]  = '{1, 0, 10, 0, 0};
    vecs[1]  = '{1, 0, 27, 0, 0};
    vecs[2]  = '{1, 0,  1, 1, 0};
    vecs[3]  = '{1, 0,  5, 1, 0};
    vecs[4]  = '{0, 0,  1, 1, 0};
    vecs[5]  = '{0, 0,  1, 1, 0};
    vecs[6]  = '{0, 0,  1, 0, 1};
    vecs[7]  = '{0, 0,  2, 0, 1};
    vecs[8]  = '{1, 0, 10, 0, 1};
    vecs[9]  = '{1, 0, 25, 0, 1};
    vecs[10] = '{1, 0,  1, 1, 1};
    vecs[11] = '{1, 1,  1, 0, 1};
    vecs[12] = '{1, 0, 15, 0, 1};
    vecs[13] = '{1, 0, 22, 0, 1};
    vecs[14] = '{1, 0,  1, 1, 1};
    vecs[15] = '{1, 1,  1, 0, 1};
    vecs[16] = '{1, 0, 10, 0, 1};
    vecs[17] = '{1, 1,  1, 0, 1};
    vecs[18] = '{1, 0, 37, 0, 1};
    vecs[19] = '{1, 0,  1, 1, 1};
    vecs[20] = '{0, 0,  2, 1, 1};
    vecs[21] = '{0, 1,  1, 0, 2};
    vecs[22] = '{0, 0,  5, 0, 2};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      repeat (vecs[i].n) tick(vecs[i].lk, vecs[i].sw);
      chk($sformatf("vec%0d_sys_rstn", i), b_sys_rstn, vecs[i].exp_rstn);
      chk($sformatf("vec%0d_ready", i), b_ready, vecs[i].exp_rstn);
      chk($sformatf("vec%0d_lost", i), b_lost, vecs[i].exp_lost);
    end

    // Default parameters: release 16+2+1024+1 cycles (+-1) after reset release.
    do_reset();
    n = 0;
    while (a_sys_rstn !== 1'b1 && n < 1200) begin
      tick(1, 0);
      n++;
    end
    checks++;
    if (n < 1042 || n > 1044) begin
      failures++;
      $display("FAIL a_release_latency: got %0d cycles expected 1042..1044", n);
    end
    chk("a_ready_at_release", a_ready, 1);

    // Lock toggling every 500 cycles never satisfies the 1024-cycle stability window.
    do_reset();
    a_hi = 0;
    for (int c = 0; c < 4000; c++) begin
      tick(((c / 500) % 2) == 0, 0);
      if (a_sys_rstn !== 1'b0) a_hi = 1;
    end
    chk("a_toggle_never_run", a_hi, 0);
    chk("a_toggle_lost", a_lost, 0);

    // 300 lock losses: counter saturates, cleared only by resetn.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      n = 0;
      while (b_sys_rstn !== 1'b1 && n < 100) begin
        tick(1, 0);
        n++;
      end
      if (n >= 100) begin
        chk($sformatf("b_reach_run_%0d", k), 0, 1);
        break;
      end
      repeat (3) tick(0, 0);
    end
    chk("b_lost_saturated", b_lost, 255);
    repeat (60) tick(1, 0);
    chk("b_lost_still_saturated", b_lost, 255);
    do_reset();

    // Randomized lock/software-reset activity against the model.
    lk = 0;
    remaining = 0;
    for (int c = 0; c < 3000; c++) begin
      if (remaining == 0) begin
        lk = ~lk;
        remaining = lk ? $urandom_range(80, 1) : $urandom_range(30, 1);
      end
      remaining--;
      sw = ($urandom_range(149, 0) == 0);
      tick(lk, sw);
    end

    // Lock held low: timeout pulses when compiled in, pll_reset stays 0 otherwise.
    do_reset();
`ifdef PLL_RST_TIMEOUT_EN
    begin
      int rises[$];
      int width;
      bit prev;
      prev = 0;
      width = 0;
      for (int c = 0; c < 600; c++) begin
        tick(0, 0);
        if (c_pll_reset === 1'b1) begin
          if (!prev) rises.push_back(c);
          width++;
        end else if (prev) begin
          chk("c_pulse_width", width, 8);
          width = 0;
        end
        prev = (c_pll_reset === 1'b1);
      end
      chk("c_pulse_count_ge3", rises.size() >= 3, 1);
      if (rises.size() >= 3) begin
        chk("c_pulse_period0", rises[1] - rises[0], 8 + H + TO);
        chk("c_pulse_period1", rises[2] - rises[1], 8 + H + TO);
      end
      chk("c_sys_rstn_low", c_sys_rstn, 0);
    end
`else
    repeat (600) tick(0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
